// File: rtl/decode_queue.sv
// ID-stage decode buffer: decodes MIPS instructions at enqueue and holds
// {instr, pc, ctrl} in a small FIFO, serialising trap-class instructions.
module decode_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 32,
  parameter bit          EN_RELU = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [15:0]              out_ctrl,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              illegal_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_RELU    = 6'b111111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

  typedef struct packed {
    logic regwrite;
    logic regdst;
    logic alusrc;
    logic branch;
    logic memtoreg;
    logic jump;
    logic jal;
    logic jr;
    logic bal;
    logic hilo_en;
    logic brk;
    logic syscall;
    logic reserve;
    logic eret;
    logic mtc0_we;
    logic mfc0;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl;
  } entry_t;

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     illegal_q, illegal_d;
  entry_t          mem_q [DEPTH];

  ctrl_t           ctrl_c;
  logic            push_c, pop_c, trap_c;

  logic [5:0] op, funct;
  logic [4:0] rs, rt;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign funct = in_instr[5:0];

  // Instruction decode into the control word stored with each entry
  always_comb begin
    ctrl_c = '0;
    unique case (op)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.alusrc   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.memtoreg = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: ctrl_c.alusrc = 1'b1;
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: ctrl_c.branch = 1'b1;
      OP_REGIMM: begin
        unique case (rt)
          RT_BLTZ, RT_BGEZ: ctrl_c.branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.branch   = 1'b1;
            ctrl_c.bal      = 1'b1;
          end
          default: ctrl_c.reserve = 1'b1;
        endcase
      end
      OP_J: ctrl_c.jump = 1'b1;
      OP_JAL: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.jal      = 1'b1;
      end
      OP_SPECIAL: begin
        unique case (funct)
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
            ctrl_c.hilo_en = 1'b1;
          FN_JR: ctrl_c.jr = 1'b1;
          FN_JALR: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.regdst   = 1'b1;
            ctrl_c.jr       = 1'b1;
          end
          FN_SYSCALL: ctrl_c.syscall = 1'b1;
          FN_BREAK:   ctrl_c.brk     = 1'b1;
          default: begin
            ctrl_c.regwrite = 1'b1;
            ctrl_c.regdst   = 1'b1;
          end
        endcase
      end
      OP_COP0: begin
        if (in_instr == INSTR_ERET) begin
          ctrl_c.eret = 1'b1;
        end else if (rs == 5'b00100 && in_instr[10:3] == 8'h00) begin
          ctrl_c.mtc0_we = 1'b1;
        end else if (rs == 5'b00000 && in_instr[10:3] == 8'h00) begin
          ctrl_c.regwrite = 1'b1;
          ctrl_c.mfc0     = 1'b1;
        end else begin
          ctrl_c.reserve = 1'b1;
        end
      end
      OP_RELU: begin
        if (EN_RELU) begin
          ctrl_c.regwrite = 1'b1;
          ctrl_c.regdst   = 1'b1;
        end else begin
          ctrl_c.reserve = 1'b1;
        end
      end
      default: ctrl_c.reserve = 1'b1;
    endcase
  end

  assign trap_c    = ctrl_c.syscall | ctrl_c.brk | ctrl_c.reserve | ctrl_c.eret;
  assign in_ready  = (count_q < CW'(DEPTH)) & (state_q == RUN) & ~flush;
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready & ~flush;

  // Next-state: flush wins, otherwise pointers/count/FSM follow push and pop
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d  = RUN;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
      unique case (state_q)
        RUN:  if (push_c && trap_c) state_d = HOLD;
        HOLD: if (pop_c && count_q == CW'(1)) state_d = RUN;
        default: state_d = RUN;
      endcase
      if (push_c && ctrl_c.reserve && illegal_q != 16'hFFFF)
        illegal_d = illegal_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Payload storage needs no reset; reads are masked while empty
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, ctrl: ctrl_c};
  end

  assign out_instr   = out_valid ? mem_q[rd_ptr_q].instr : '0;
  assign out_pc      = out_valid ? mem_q[rd_ptr_q].pc    : '0;
  assign out_ctrl    = out_valid ? mem_q[rd_ptr_q].ctrl  : '0;
  assign count       = count_q;
  assign illegal_cnt = illegal_q;

endmodule
